sync_fifo_vr: RTL and testbench
===============================

// Module: sync_fifo_vr
// PURPOSE
//   Synchronous single-clock FIFO with valid/ready handshakes; next generation of the lab FIFO.
//   Adds non-power-of-two DEPTH, an occupancy count, registered almost-full/almost-empty flags,
//   a synchronous flush and a clearable high-water mark. Buffers streams between MME pipeline
//   stages and bench drivers; occupancy/HWM outputs feed the performance monitors.
// PARAMETERS
//   DEPTH       16        number of entries, any integer >= 2 (not limited to powers of two)
//   DATA_WIDTH  32        payload width in bits
//   AF_LEVEL    DEPTH-2   almost_full_o asserted when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL    2         almost_empty_o asserted when count <= AE_LEVEL (0..DEPTH-1)
//   CNT_W       $clog2(DEPTH+1)  derived localparam, width of count/HWM
// PORTS
//   clk             in   1           clock, all logic on rising edge
//   rst_n           in   1           reset, synchronous, active-low
//   flush_i         in   1           drop all stored entries
//   wvalid_i        in   1           write request
//   wready_o        out  1           FIFO can accept (= !full)
//   wdata_i         in   DATA_WIDTH  write payload
//   rvalid_o        out  1           head entry valid (= !empty)
//   rready_i        in   1           consumer accepts head entry
//   rdata_o         out  DATA_WIDTH  head entry, first-word-fall-through
//   count_o         out  CNT_W       current occupancy, 0..DEPTH
//   almost_full_o   out  1           count_o >= AF_LEVEL
//   almost_empty_o  out  1           count_o <= AE_LEVEL
//   hwm_o           out  CNT_W       maximum occupancy since reset/clear
//   hwm_clr_i       in   1           restart high-water tracking
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): wrptr=rdptr=0, count_o=0, wready_o=1, rvalid_o=0,
//     almost_full_o=(AF_LEVEL==0 ? 1:0)->0 for legal AF_LEVEL, almost_empty_o=1, hwm_o=0.
//     Storage array is NOT reset; rdata_o is don't-care while rvalid_o=0.
//   - push = wvalid_i & wready_o; pop = rvalid_o & rready_i. Transfers only on these.
//   - wvalid_i while wready_o=0 is ignored (no write, no error); rready_i while rvalid_o=0 ignored.
//   - Pointers are 0..DEPTH-1 binary; increment wraps DEPTH-1 -> 0 (no power-of-two masking).
//   - Write: on push, mem[wrptr] <= wdata_i, wrptr advances. Read: rdata_o = mem[rdptr]
//     combinationally; on pop rdptr advances. Written data visible on rdata_o 1 cycle after push.
//   - count_n = count + push - pop; push&pop together leaves count unchanged (legal when
//     0<count<DEPTH; at count==DEPTH only pop occurs, at count==0 only push occurs).
//   - All status outputs registered from next-state values: wready_o=(count_n!=DEPTH),
//     rvalid_o=(count_n!=0), almost_full_o=(count_n>=AF_LEVEL), almost_empty_o=(count_n<=AE_LEVEL).
//   - Flush: highest priority after reset. flush_i=1 -> next cycle wrptr=rdptr=0, count=0,
//     status as at reset; any same-cycle push/pop is discarded (no write into array).
//   - HWM: flush does not change hwm_o. hwm_clr_i=1 -> hwm_o <= count_n (0 if flushing);
//     otherwise hwm_o <= max(hwm_o, count_n). Width CNT_W, never saturates beyond DEPTH.
//   - Reset asserted mid-stream behaves as flush plus hwm_o=0; in-flight handshakes lost.
// TESTING
//   1 DEPTH=16: 16 pushes 0..15, no pops -> wready_o=0 after 16th, count_o=16, almost_full_o
//     from count 14, 17th wvalid_i ignored; then 16 pops return 0..15 in order, rvalid_o=0 after.
//   2 DEPTH=12 (non-pow2): 3 rounds of 8 pushes/8 pops (pointer wraps 11->0) -> data in order,
//     count_o peaks 8, no loss/duplication.
//   3 Simultaneous push+pop at count=5 for 20 cycles -> count_o stays 5, FIFO order held; at
//     count=16 wvalid&rready -> only pop, count 15; at count=0 -> only push, count 1.
//   4 Fill to 10, assert flush_i with wvalid_i=1 -> next cycle count_o=0, rvalid_o=0,
//     almost_empty_o=1, hwm_o=10; next push X appears on rdata_o as head.
//   5 HWM: reach 9, drain to 3, pulse hwm_clr_i -> hwm_o=3; push to 7 -> hwm_o=7.
//   6 rst_n low for 1 cycle at count=6 -> all outputs at reset values next cycle, hwm_o=0.
//   Bench: scoreboard queue model, random wvalid/rready 50% for 10k cycles at DEPTH 2/12/16.

Source files
------------

// File: rtl/sync_fifo_vr.sv
// ---------------------------------------------------------------------------
// sync_fifo_vr
//   Single-clock FIFO with valid/ready handshakes on both sides. Supports any
//   DEPTH >= 2, including depths that are not a power of two. It also
//   provides an occupancy count, registered almost-full and almost-empty
//   flags, a synchronous flush, and a clearable high-water mark.
//
// Ports
//   clk             clock, rising edge
//   rst_n           synchronous active-low reset
//   flush_i         drop all stored entries (next cycle empty)
//   wvalid_i        write request
//   wready_o        FIFO can accept a write (not full)
//   wdata_i         write payload
//   rvalid_o        head entry valid (not empty)
//   rready_i        consumer accepts head entry
//   rdata_o         head entry, first-word-fall-through
//   count_o         current occupancy, 0..DEPTH
//   almost_full_o   count_o >= AF_LEVEL
//   almost_empty_o  count_o <= AE_LEVEL
//   hwm_o           maximum occupancy since reset or last clear
//   hwm_clr_i       restart high-water tracking from the next occupancy
// ---------------------------------------------------------------------------
module sync_fifo_vr #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_W-1:0]      hwm_o,
    input  logic                  hwm_clr_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_wready;
    logic                  r_rvalid;
    logic                  r_almostFull;
    logic                  r_almostEmpty;
    logic [CNT_W-1:0]      r_hwm;

    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_countNext;

    // Pointers wrap explicitly at DEPTH-1 so that non-power-of-two depths
    // never index past the end of the storage array.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A handshake completes only when the matching status flag is set.
    // As a result, at full only a pop can happen and at empty only a push.
    assign w_push = wvalid_i & r_wready;
    assign w_pop  = r_rvalid & rready_i;

    // The next occupancy drives every registered status flag. This keeps the
    // flags aligned with count_o in the same cycle.
    always_comb begin
        w_countNext = r_count;
        if (flush_i) begin
            w_countNext = '0;
        end else if (w_push && !w_pop) begin
            w_countNext = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - CNT_W'(1);
        end
    end

    // Control and status state. Flush empties the FIFO but keeps the
    // high-water mark, unless a clear is requested in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_wready      <= 1'b1;
            r_rvalid      <= 1'b0;
            r_almostFull  <= (AF_LEVEL == 0);
            r_almostEmpty <= 1'b1;
            r_hwm         <= '0;
        end else begin
            r_count       <= w_countNext;
            r_wready      <= (w_countNext != FULL_CNT);
            r_rvalid      <= (w_countNext != '0);
            r_almostFull  <= (w_countNext >= AF_CNT);
            r_almostEmpty <= (w_countNext <= AE_CNT);

            if (flush_i) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= ptrInc(r_wrPtr);
                end
                if (w_pop) begin
                    r_rdPtr <= ptrInc(r_rdPtr);
                end
            end

            if (hwm_clr_i) begin
                r_hwm <= w_countNext;
            end else if (w_countNext > r_hwm) begin
                r_hwm <= w_countNext;
            end
        end
    end

    // Storage has no reset. Writes are suppressed during reset and flush, so
    // a handshake that is in flight at that moment is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && w_push) begin
            r_mem[r_wrPtr] <= wdata_i;
        end
    end

    assign wready_o       = r_wready;
    assign rvalid_o       = r_rvalid;
    assign rdata_o        = r_mem[r_rdPtr];
    assign count_o        = r_count;
    assign almost_full_o  = r_almostFull;
    assign almost_empty_o = r_almostEmpty;
    assign hwm_o          = r_hwm;

endmodule

// File: tb/tb_sync_fifo_vr.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_vr
//   Drives three FIFOs (DEPTH 2, 12 and 16) from one shared input stream.
//   Each FIFO has its own queue-based reference model. A negedge process
//   compares every output against the model on every cycle. Directed
//   sections add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_sync_fifo_vr;

    localparam int NDUT = 3;
    localparam int DEP [NDUT] = '{2, 12, 16};
    localparam int AFL [NDUT] = '{1, 10, 14};
    localparam int AEL [NDUT] = '{1, 2, 2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic        rready = 1'b0;
    logic        hwmClr = 1'b0;

    logic        wready2, rvalid2, af2, ae2;
    logic [31:0] rdata2;
    logic [1:0]  count2, hwm2;
    logic        wready12, rvalid12, af12, ae12;
    logic [31:0] rdata12;
    logic [3:0]  count12, hwm12;
    logic        wready16, rvalid16, af16, ae16;
    logic [31:0] rdata16;
    logic [4:0]  count16, hwm16;

    int          obsCount [NDUT];
    int          obsHwm [NDUT];
    logic        obsWready [NDUT];
    logic        obsRvalid [NDUT];
    logic        obsAf [NDUT];
    logic        obsAe [NDUT];
    logic [31:0] obsRdata [NDUT];

    logic [31:0] mq [NDUT][$];
    int          mHwm [NDUT];
    bit          modelValid = 1'b0;

    int          checkCount = 0;
    int          passCount = 0;

    always #5 clk = ~clk;

    sync_fifo_vr #(.DEPTH(2), .DATA_WIDTH(32), .AF_LEVEL(1), .AE_LEVEL(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .wvalid_i(wvalid), .wready_o(wready2), .wdata_i(wdata),
        .rvalid_o(rvalid2), .rready_i(rready), .rdata_o(rdata2),
        .count_o(count2), .almost_full_o(af2), .almost_empty_o(ae2),
        .hwm_o(hwm2), .hwm_clr_i(hwmClr)
    );

    sync_fifo_vr #(.DEPTH(12), .DATA_WIDTH(32), .AF_LEVEL(10), .AE_LEVEL(2)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .wvalid_i(wvalid), .wready_o(wready12), .wdata_i(wdata),
        .rvalid_o(rvalid12), .rready_i(rready), .rdata_o(rdata12),
        .count_o(count12), .almost_full_o(af12), .almost_empty_o(ae12),
        .hwm_o(hwm12), .hwm_clr_i(hwmClr)
    );

    sync_fifo_vr #(.DEPTH(16), .DATA_WIDTH(32)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .wvalid_i(wvalid), .wready_o(wready16), .wdata_i(wdata),
        .rvalid_o(rvalid16), .rready_i(rready), .rdata_o(rdata16),
        .count_o(count16), .almost_full_o(af16), .almost_empty_o(ae16),
        .hwm_o(hwm16), .hwm_clr_i(hwmClr)
    );

    // Collect each instance's outputs into arrays so the compare loop and
    // the directed checks can index them by instance.
    always_comb begin
        obsCount[0] = int'(count2);   obsHwm[0] = int'(hwm2);
        obsCount[1] = int'(count12);  obsHwm[1] = int'(hwm12);
        obsCount[2] = int'(count16);  obsHwm[2] = int'(hwm16);
        obsWready[0] = wready2;  obsWready[1] = wready12;  obsWready[2] = wready16;
        obsRvalid[0] = rvalid2;  obsRvalid[1] = rvalid12;  obsRvalid[2] = rvalid16;
        obsAf[0] = af2;          obsAf[1] = af12;          obsAf[2] = af16;
        obsAe[0] = ae2;          obsAe[1] = ae12;          obsAe[2] = ae16;
        obsRdata[0] = rdata2;    obsRdata[1] = rdata12;    obsRdata[2] = rdata16;
    end

    // Record one comparison. Only this task updates the pass and total counts.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge. Return 1 time unit
    // after the following edge so that callers sample settled outputs.
    task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic rr,
                                 input logic fl, input logic hc);
        wvalid = wv;
        wdata  = wd;
        rready = rr;
        flush  = fl;
        hwmClr = hc;
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        rready = 1'b0;
        flush  = 1'b0;
        hwmClr = 1'b0;
    endtask

    // Reference model: one queue per FIFO. A handshake is honoured only when
    // the queue is not full (push) or not empty (pop), judged before the edge.
    // The high-water mark follows the rules for clear, flush and reset.
    always @(posedge clk) begin
        int  sz;
        bit  doPush;
        bit  doPop;
        for (int k = 0; k < NDUT; k++) begin
            sz     = mq[k].size();
            doPush = wvalid && (sz != DEP[k]);
            doPop  = rready && (sz != 0);
            if (!rst_n) begin
                mq[k].delete();
                mHwm[k] = 0;
            end else if (flush) begin
                mq[k].delete();
                if (hwmClr) mHwm[k] = 0;
            end else begin
                if (doPop) void'(mq[k].pop_front());
                if (doPush) mq[k].push_back(wdata);
                sz = mq[k].size();
                if (hwmClr) mHwm[k] = sz;
                else if (sz > mHwm[k]) mHwm[k] = sz;
            end
        end
        if (!rst_n) modelValid = 1'b1;
    end

    // Every falling edge, compare all outputs of all three FIFOs with the
    // model. Compare rdata only while the model holds at least one entry.
    always @(negedge clk) begin
        int sz;
        if (modelValid) begin
            for (int k = 0; k < NDUT; k++) begin
                sz = mq[k].size();
                checkOutput($sformatf("d%0d count", DEP[k]), obsCount[k], sz);
                checkOutput($sformatf("d%0d wready", DEP[k]), obsWready[k], (sz != DEP[k]));
                checkOutput($sformatf("d%0d rvalid", DEP[k]), obsRvalid[k], (sz != 0));
                checkOutput($sformatf("d%0d almost_full", DEP[k]), obsAf[k], (sz >= AFL[k]));
                checkOutput($sformatf("d%0d almost_empty", DEP[k]), obsAe[k], (sz <= AEL[k]));
                checkOutput($sformatf("d%0d hwm", DEP[k]), obsHwm[k], mHwm[k]);
                if (sz != 0) begin
                    checkOutput($sformatf("d%0d rdata", DEP[k]), obsRdata[k], mq[k][0]);
                end
            end
        end
    end

    // Directed scenarios, then a long random phase.
    initial begin
        $display("[TB] start");
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        checkOutput("reset count", obsCount[2], 0);
        checkOutput("reset wready", obsWready[2], 1);
        checkOutput("reset rvalid", obsRvalid[2], 0);
        checkOutput("reset almost_full", obsAf[2], 0);
        checkOutput("reset almost_empty", obsAe[2], 1);
        checkOutput("reset hwm", obsHwm[2], 0);

        // Fill depth 16 completely, then try one push too many.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            if (i == 12) checkOutput("fill af at 13", obsAf[2], 0);
            if (i == 13) checkOutput("fill af at 14", obsAf[2], 1);
        end
        checkOutput("fill count 16", obsCount[2], 16);
        checkOutput("fill wready 0", obsWready[2], 0);
        applyStimulus(1'b1, 32'd99, 1'b0, 1'b0, 1'b0);
        checkOutput("overfill ignored", obsCount[2], 16);
        checkOutput("fill hwm 16", obsHwm[2], 16);
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain order", obsRdata[2], i);
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("drain rvalid 0", obsRvalid[2], 0);
        checkOutput("drain count 0", obsCount[2], 0);

        // Depth 12: three rounds of 8 pushes and 8 pops. The pointers wrap
        // past entry 11.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'(1000 + r * 8 + i), 1'b0, 1'b0, 1'b0);
            checkOutput("d12 round count", obsCount[1], 8);
            for (int i = 0; i < 8; i++) begin
                checkOutput("d12 round order", obsRdata[1], 1000 + r * 8 + i);
                applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
            end
            checkOutput("d12 round empty", obsCount[1], 0);
        end

        // Simultaneous push and pop at count 5, then at full and at empty.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'(100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("pushpop head", obsRdata[2], (i < 5) ? 100 + i : 200 + i - 5);
            applyStimulus(1'b1, 32'(200 + i), 1'b1, 1'b0, 1'b0);
            checkOutput("pushpop count", obsCount[2], 5);
        end
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 32'(300 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("refill count 16", obsCount[2], 16);
        applyStimulus(1'b1, 32'd500, 1'b1, 1'b0, 1'b0);
        checkOutput("full pushpop count", obsCount[2], 15);
        checkOutput("full pushpop wready", obsWready[2], 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'd600, 1'b1, 1'b0, 1'b0);
        checkOutput("empty pushpop count", obsCount[2], 1);
        checkOutput("empty pushpop data", obsRdata[2], 600);

        // Flush with a simultaneous write request.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'(700 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("preflush count", obsCount[2], 10);
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0);
        checkOutput("flush count", obsCount[2], 0);
        checkOutput("flush rvalid", obsRvalid[2], 0);
        checkOutput("flush almost_empty", obsAe[2], 1);
        checkOutput("flush hwm kept", obsHwm[2], 10);
        applyStimulus(1'b1, 32'hABCD, 1'b0, 1'b0, 1'b0);
        checkOutput("postflush rvalid", obsRvalid[2], 1);
        checkOutput("postflush head", obsRdata[2], 32'hABCD);

        // High-water mark: reach 9, drain to 3, clear, then climb to 7.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'(800 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("hwm at 9", obsHwm[2], 9);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("hwm drained count", obsCount[2], 3);
        checkOutput("hwm after drain", obsHwm[2], 9);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("hwm cleared", obsHwm[2], 3);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(850 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("hwm regrow count", obsCount[2], 7);
        checkOutput("hwm regrow", obsHwm[2], 7);

        // Reset pulse in the middle of traffic.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'(900 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("prereset count", obsCount[2], 6);
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'd999, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        checkOutput("midreset count", obsCount[2], 0);
        checkOutput("midreset wready", obsWready[2], 1);
        checkOutput("midreset rvalid", obsRvalid[2], 0);
        checkOutput("midreset almost_full", obsAf[2], 0);
        checkOutput("midreset almost_empty", obsAe[2], 1);
        checkOutput("midreset hwm", obsHwm[2], 0);

        // Random traffic: 50% write and read requests, with occasional
        // flushes and high-water-mark clears.
        for (int n = 0; n < 10000; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 63) == 0), ($urandom_range(0, 99) == 0));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
